// File: rtl/rbw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : rbw_scheduler
//  Purpose  : Two-task read-issue arbiter with a small read-before-write
//             (RBW) scoreboard. Marked reads post a notice on their address;
//             later reads of the same task/address are held off until a
//             matching write retires the notice.
//  Revision : 1.0 - initial release
// ============================================================================
module rbw_scheduler #(
  parameter int L  = 3,      // address MSB, addresses are L+1 bits
  parameter int D  = 4,      // scoreboard depth (2..8)
  parameter bit PT = 1'b1    // same-cycle matching write resolves a hazard
) (
  input  logic       clk,
  input  logic       a_rst,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [L:0] i_radr0,
  input  logic [L:0] i_radr1,
  input  logic       i_mark0,
  input  logic       i_mark1,
  input  logic       ws,
  input  logic       w_ts,
  input  logic [L:0] ws_adr,
  output logic       o_gnt0,
  output logic       o_gnt1,
  output logic       o_haz0,
  output logic       o_haz1,
  output logic       o_full,
  output logic [3:0] o_cnt
);

  localparam int c_IDX_W = (D > 1) ? $clog2(D) : 1;

  // Scoreboard state
  logic [D-1:0] r_valid;
  logic [D-1:0] r_ts;
  logic [L:0]   r_adr [D];
  // 0: task 0 wins the next tie, 1: task 1 wins the next tie
  logic         r_rr_pri;

  logic [D-1:0]       w_clr;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_elig0;
  logic               w_elig1;
  logic               w_alloc;
  logic               w_alloc_ts;
  logic [L:0]         w_alloc_adr;
  logic [c_IDX_W-1:0] w_free_idx;
  logic [3:0]         w_cnt;

  // Per-entry retire: a write by the owning task to the noted address
  generate
    for (genvar g = 0; g < D; g++) begin : g_clr
      assign w_clr[g] = r_valid[g] & ws & (r_ts[g] == w_ts) & (r_adr[g] == ws_adr);
    end
  endgenerate

  // Hazard lookup for each task; a retiring entry is ignored when passthrough is on
  always_comb begin
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
    for (int e = 0; e < D; e++) begin
      if (r_valid[e] && !(PT && w_clr[e])) begin
        if (!r_ts[e] && (r_adr[e] == i_radr0)) w_hit0 = 1'b1;
        if ( r_ts[e] && (r_adr[e] == i_radr1)) w_hit1 = 1'b1;
      end
    end
  end

  assign o_haz0 = i_req0 & w_hit0;
  assign o_haz1 = i_req1 & w_hit1;

  // Occupancy from registered valid bits only, so a freed slot shows next cycle
  always_comb begin
    w_cnt = 4'd0;
    for (int e = 0; e < D; e++) begin
      w_cnt = w_cnt + {3'b000, r_valid[e]};
    end
  end

  assign o_cnt  = w_cnt;
  assign o_full = &r_valid;

  // Eligibility and round-robin grant; marked reads need a free slot
  always_comb begin
    w_elig0 = i_req0 & ~o_haz0 & ~(i_mark0 & o_full);
    w_elig1 = i_req1 & ~o_haz1 & ~(i_mark1 & o_full);
    o_gnt0  = w_elig0 & (~w_elig1 | ~r_rr_pri);
    o_gnt1  = w_elig1 & (~w_elig0 |  r_rr_pri);
  end

  // Allocation request and lowest-index free slot
  always_comb begin
    w_alloc     = (o_gnt0 & i_mark0) | (o_gnt1 & i_mark1);
    w_alloc_ts  = o_gnt1;
    w_alloc_adr = o_gnt1 ? i_radr1 : i_radr0;
    w_free_idx  = '0;
    for (int e = D - 1; e >= 0; e--) begin
      if (!r_valid[e]) w_free_idx = c_IDX_W'(e);
    end
  end

  // Scoreboard update: retire matches, then allocate (allocated slot is never a retiring one)
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_valid <= '0;
      r_ts    <= '0;
      for (int e = 0; e < D; e++) begin
        r_adr[e] <= '0;
      end
    end else begin
      r_valid <= r_valid & ~w_clr;
      if (w_alloc) begin
        r_valid[w_free_idx] <= 1'b1;
        r_ts[w_free_idx]    <= w_alloc_ts;
        r_adr[w_free_idx]   <= w_alloc_adr;
      end
    end
  end

  // Round-robin pointer moves to the other task after each grant
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_rr_pri <= 1'b0;
    end else if (o_gnt0) begin
      r_rr_pri <= 1'b1;
    end else if (o_gnt1) begin
      r_rr_pri <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rbw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rbw_scheduler
//  Purpose  : Directed self-checking bench for rbw_scheduler (PT=1 and PT=0)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rbw_scheduler;

  logic       clk;
  logic       a_rst;
  logic       req0, req1, mark0, mark1, ws, w_ts;
  logic [3:0] radr0, radr1, ws_adr;

  logic       gnt0, gnt1, haz0, haz1, full;
  logic [3:0] cnt;
  logic       n_gnt0, n_gnt1, n_haz0, n_haz1, n_full;
  logic [3:0] n_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rbw_scheduler #(.L(3), .D(4), .PT(1'b1)) dut (
    .clk(clk), .a_rst(a_rst),
    .i_req0(req0), .i_req1(req1), .i_radr0(radr0), .i_radr1(radr1),
    .i_mark0(mark0), .i_mark1(mark1),
    .ws(ws), .w_ts(w_ts), .ws_adr(ws_adr),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_haz0(haz0), .o_haz1(haz1),
    .o_full(full), .o_cnt(cnt)
  );

  rbw_scheduler #(.L(3), .D(4), .PT(1'b0)) dut_np (
    .clk(clk), .a_rst(a_rst),
    .i_req0(req0), .i_req1(req1), .i_radr0(radr0), .i_radr1(radr1),
    .i_mark0(mark0), .i_mark1(mark1),
    .ws(ws), .w_ts(w_ts), .ws_adr(ws_adr),
    .o_gnt0(n_gnt0), .o_gnt1(n_gnt1), .o_haz0(n_haz0), .o_haz1(n_haz1),
    .o_full(n_full), .o_cnt(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; mark0 = 0; mark1 = 0; ws = 0; w_ts = 0;
    radr0 = 0; radr1 = 0; ws_adr = 0;
  endtask

  initial begin
    a_rst = 1'b0;
    idle();
    req0 = 1; req1 = 1;
    #1;
    check("rst_cnt",  32'(cnt),  0);
    check("rst_full", 32'(full), 0);
    check("rst_haz0", 32'(haz0), 0);
    check("rst_gnt0", 32'(gnt0), 1);
    check("rst_gnt1", 32'(gnt1), 0);
    tick(); tick();
    a_rst = 1'b1;

    // Round-robin with both tasks requesting: 0,1,0
    #1;
    check("rr_c1_g0", 32'(gnt0), 1);
    check("rr_c1_g1", 32'(gnt1), 0);
    tick(); #1;
    check("rr_c2_g1", 32'(gnt1), 1);
    check("rr_c2_g0", 32'(gnt0), 0);
    tick(); #1;
    check("rr_c3_g0", 32'(gnt0), 1);
    check("rr_c3_g1", 32'(gnt1), 0);
    tick();

    // Hazard on own pending notice, resolved by same-cycle write (PT=1)
    idle(); req0 = 1; mark0 = 1; radr0 = 5; #1;
    check("haz_alloc_g0", 32'(gnt0), 1);
    tick();
    mark0 = 0; #1;
    check("haz_haz0", 32'(haz0), 1);
    check("haz_gnt0", 32'(gnt0), 0);
    check("haz_cnt1", 32'(cnt),  1);
    ws = 1; w_ts = 0; ws_adr = 5; #1;
    check("pt_haz0", 32'(haz0), 0);
    check("pt_gnt0", 32'(gnt0), 1);
    tick();
    idle(); #1;
    check("pt_cnt0", 32'(cnt), 0);

    // Other task's read and write do not interact with task 0's notice
    req0 = 1; mark0 = 1; radr0 = 5; #1;
    check("xt_alloc_g0", 32'(gnt0), 1);
    tick();
    idle(); req1 = 1; radr1 = 5; ws = 1; w_ts = 1; ws_adr = 5; #1;
    check("xt_haz1", 32'(haz1), 0);
    check("xt_gnt1", 32'(gnt1), 1);
    tick();
    idle(); #1;
    check("xt_cnt1", 32'(cnt), 1);
    ws = 1; w_ts = 0; ws_adr = 5;
    tick();
    idle(); #1;
    check("xt_cnt0", 32'(cnt), 0);

    // Fill the scoreboard with addresses 1..4
    for (int k = 1; k <= 4; k++) begin
      req0 = 1; mark0 = 1; radr0 = 4'(k); #1;
      check("fill_gnt0", 32'(gnt0), 1);
      tick();
    end
    idle(); #1;
    check("full_flag", 32'(full), 1);
    check("full_cnt",  32'(cnt),  4);
    req0 = 1; mark0 = 1; radr0 = 6; #1;
    check("full_marked_blk", 32'(gnt0), 0);
    check("full_marked_haz", 32'(haz0), 0);
    mark0 = 0; #1;
    check("full_unmarked_g", 32'(gnt0), 1);
    radr0 = 3; #1;
    check("full_pend_haz", 32'(haz0), 1);
    check("full_pend_gnt", 32'(gnt0), 0);
    // Free address 2 while a marked read waits: still blocked this cycle
    mark0 = 1; radr0 = 9; ws = 1; w_ts = 0; ws_adr = 2; #1;
    check("free_same_cyc", 32'(gnt0), 0);
    tick();
    ws = 0; #1;
    check("free_cnt3",  32'(cnt),  3);
    check("free_full0", 32'(full), 0);
    check("free_gnt0",  32'(gnt0), 1);
    tick();
    idle(); #1;
    check("refill_cnt",  32'(cnt),  4);
    check("refill_full", 32'(full), 1);
    check("refill_slot1", 32'(dut.r_adr[1]), 9);
    req0 = 1; radr0 = 9; #1;
    check("refill_haz", 32'(haz0), 1);

    // Asynchronous reset mid-cycle with three pending notices
    idle(); ws = 1; w_ts = 0; ws_adr = 4;
    tick();
    idle(); #1;
    check("pre_rst_cnt", 32'(cnt), 3);
    #2 a_rst = 1'b0;
    #1;
    check("arst_cnt",  32'(cnt),  0);
    check("arst_full", 32'(full), 0);
    #2 a_rst = 1'b1;
    req0 = 1; radr0 = 1; #1;
    check("arst_haz0", 32'(haz0), 0);
    check("arst_gnt0", 32'(gnt0), 1);
    req1 = 1; #1;
    check("arst_tie_g0", 32'(gnt0), 1);
    tick();

    // PT=0: same-cycle clearing write does not unblock, next cycle does
    idle(); a_rst = 1'b0; #2 a_rst = 1'b1;
    req0 = 1; mark0 = 1; radr0 = 7; #1;
    check("np_alloc_g0", 32'(n_gnt0), 1);
    tick();
    mark0 = 0; ws = 1; w_ts = 0; ws_adr = 7; #1;
    check("np_haz0_now", 32'(n_haz0), 1);
    check("np_gnt0_now", 32'(n_gnt0), 0);
    check("pt_gnt0_now", 32'(gnt0),   1);
    tick();
    ws = 0; #1;
    check("np_haz0_next", 32'(n_haz0), 0);
    check("np_gnt0_next", 32'(n_gnt0), 1);
    check("np_cnt0",      32'(n_cnt),  0);
    tick();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
